// File: rtl/syskey_debounce.sv
// syskey_debounce
//
// Conditions the raw system push-keys before they reach the system-key PIO.
// Each key is synchronised with two flops and debounced with its own
// qualification counter. A single free-running prescaler is shared by all
// keys. A changed level is accepted only after it persists for STABLE_TICKS
// consecutive prescaler ticks.
//
// Optional feature, selected by the macro SYSKEY_DEBOUNCE_IRQ_EN:
//   defined   - sticky per-key press latch plus a registered irq (OR of latch)
//   undefined - press_latch and irq tie to 0, irq_clear is ignored
//
// Parameters:
//   WIDTH        number of keys
//   TICK_DIV     prescaler period in clk cycles (>= 1)
//   STABLE_TICKS ticks a changed level must persist before acceptance (>= 1)
//   ACTIVE_LOW   1: raw pin low = pressed, 0: raw pin high = pressed
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   key_raw      asynchronous key pins
//   key_state    debounced state, 1 = pressed (to PIO in_port)
//   key_press    one-cycle strobe on accepted 0->1 of key_state
//   key_release  one-cycle strobe on accepted 1->0 of key_state
//   irq_clear    per-key clear of the press latch
//   press_latch  sticky record of presses
//   irq          OR of press_latch, one cycle late
module syskey_debounce #(
    parameter int unsigned WIDTH        = 3,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 16,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] press_latch,
    output logic             irq
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntW  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
    localparam logic [CntW-1:0]  CntLast   = CntW'(STABLE_TICKS - 1);
    // Pin level of a released key; the sync chain resets to it so that no
    // spurious transition is seen as reset releases.
    localparam logic [WIDTH-1:0] IdleLevel = {WIDTH{ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sample;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= IdleLevel;
            sync2_q <= IdleLevel;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        sample = ACTIVE_LOW ? ~sync2_q : sync2_q;
    end

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [TickW-1:0] presc_q;
    logic [TickW-1:0] presc_d;
    logic             tick;

    always_comb begin
        tick    = (presc_q == TickLast);
        presc_d = tick ? '0 : presc_q + TickW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-key qualification
    // ------------------------------------------------------------------
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] rel_q;
    logic [WIDTH-1:0] rel_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sample[i] == state_q[i]) begin
                // Any return to the accepted level discards progress.
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CntLast) begin
                    state_d[i] = ~state_q[i];
                    cnt_d[i]   = '0;
                    if (state_q[i]) begin
                        rel_d[i] = 1'b1;
                    end else begin
                        press_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

    // ------------------------------------------------------------------
    // Press latch / interrupt
    // ------------------------------------------------------------------
`ifdef SYSKEY_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] latch_q;
    logic [WIDTH-1:0] latch_d;
    logic             irq_q;

    // The latch becomes visible together with key_press and the set term
    // stays active for the whole strobe cycle, so a clear presented while
    // key_press is high loses to the set.
    always_comb begin
        latch_d = press_d | press_q | (latch_q & ~irq_clear);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            latch_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            latch_q <= latch_d;
            irq_q   <= |latch_q;
        end
    end

    assign press_latch = latch_q;
    assign irq         = irq_q;
`else
    logic unused_irq_clear;

    assign unused_irq_clear = ^irq_clear;
    assign press_latch      = '0;
    assign irq              = 1'b0;
`endif

endmodule
